// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the instruction/data memory arbiter.
// State encodings, grant identifiers and the round-robin grant choice live here.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2,
        ARB_DONE = 2'd3
    } arb_state_e;

    localparam logic ARB_GRANT_I = 1'b0;
    localparam logic ARB_GRANT_D = 1'b1;

    // A lone requester wins outright; on a tie the side that was not served last wins.
    function automatic logic pickGrant(input logic iReq, input logic dReq, input logic lastGrant);
        logic grant;
        if (iReq && dReq) begin
            grant = ~lastGrant;
        end else if (dReq) begin
            grant = ARB_GRANT_D;
        end else begin
            grant = ARB_GRANT_I;
        end
        return grant;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one memory request/response port between the fetch and data sides,
// one end-to-end transaction at a time, with a one-cycle completion pulse.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int D_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_req_valid_i,
    input  logic [ADDR_W-1:0] icache_addr_i,
    input  logic              icache_data_wen_i,
    input  logic [DATA_W-1:0] icache_data_i,
    output logic              icache_data_valid_o,
    output logic [DATA_W-1:0] icache_data_o,
    input  logic              dcache_req_valid_i,
    input  logic [ADDR_W-1:0] dcache_addr_i,
    input  logic              dcache_data_wen_i,
    input  logic [DATA_W-1:0] dcache_data_i,
    output logic              dcache_data_valid_o,
    output logic [DATA_W-1:0] dcache_data_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_wen_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_resp_valid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    // Reset makes the favoured side look as if the other one was served last.
    localparam logic LAST_GRANT_RST = (D_FIRST != 0) ? ARB_GRANT_I : ARB_GRANT_D;

    arb_state_e        r_state;
    arb_state_e        w_nextState;
    logic              r_grant;
    logic              r_lastGrant;
    logic              w_grant;
    logic              w_anyReq;
    logic [ADDR_W-1:0] r_memAddr;
    logic              r_memWen;
    logic [DATA_W-1:0] r_memWdata;
    logic [DATA_W-1:0] r_icacheData;
    logic [DATA_W-1:0] r_dcacheData;

    assign w_anyReq = icache_req_valid_i || dcache_req_valid_i;

    always_comb begin
        w_nextState = r_state;
        w_grant     = pickGrant(icache_req_valid_i, dcache_req_valid_i, r_lastGrant);
        case (r_state)
            ARB_IDLE: if (w_anyReq)         w_nextState = ARB_REQ;
            ARB_REQ:  if (mem_req_ready_i)  w_nextState = ARB_RESP;
            ARB_RESP: if (mem_resp_valid_i) w_nextState = ARB_DONE;
            ARB_DONE:                       w_nextState = ARB_IDLE;
            default:                        w_nextState = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ARB_IDLE;
            r_grant      <= ARB_GRANT_I;
            r_lastGrant  <= LAST_GRANT_RST;
            r_memAddr    <= '0;
            r_memWen     <= 1'b0;
            r_memWdata   <= '0;
            r_icacheData <= '0;
            r_dcacheData <= '0;
        end else begin
            r_state <= w_nextState;
            // Request fields are captured once at grant so later input changes are ignored.
            if (r_state == ARB_IDLE && w_anyReq) begin
                r_grant    <= w_grant;
                r_memAddr  <= (w_grant == ARB_GRANT_D) ? dcache_addr_i     : icache_addr_i;
                r_memWen   <= (w_grant == ARB_GRANT_D) ? dcache_data_wen_i : icache_data_wen_i;
                r_memWdata <= (w_grant == ARB_GRANT_D) ? dcache_data_i     : icache_data_i;
            end
            if (r_state == ARB_RESP && mem_resp_valid_i) begin
                r_lastGrant <= r_grant;
                if (r_grant == ARB_GRANT_D) begin
                    r_dcacheData <= mem_rdata_i;
                end else begin
                    r_icacheData <= mem_rdata_i;
                end
            end
        end
    end

    assign mem_req_valid_o     = (r_state == ARB_REQ);
    assign mem_addr_o          = r_memAddr;
    assign mem_wen_o           = r_memWen;
    assign mem_wdata_o         = r_memWdata;
    assign icache_data_valid_o = (r_state == ARB_DONE) && (r_grant == ARB_GRANT_I);
    assign dcache_data_valid_o = (r_state == ARB_DONE) && (r_grant == ARB_GRANT_D);
    assign icache_data_o       = r_icacheData;
    assign dcache_data_o       = r_dcacheData;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a small memory responder, a monitor that
// checks request fields and completions against queued expectations, and directed scenarios.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    typedef struct {
        logic              side;
        logic [ADDR_W-1:0] addr;
        logic              wen;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
    } txn_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              icache_req_valid_i, icache_data_wen_i, icache_data_valid_o;
    logic [ADDR_W-1:0] icache_addr_i;
    logic [DATA_W-1:0] icache_data_i, icache_data_o;
    logic              dcache_req_valid_i, dcache_data_wen_i, dcache_data_valid_o;
    logic [ADDR_W-1:0] dcache_addr_i;
    logic [DATA_W-1:0] dcache_data_i, dcache_data_o;
    logic              mem_req_valid_o, mem_req_ready_i, mem_wen_o, mem_resp_valid_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o, mem_rdata_i;

    txn_t              expQ[$];
    int                assertCount = 0;
    int                failCount = 0;
    int                readyDelay = 0;
    int                respDelay = 0;
    int                iPulses = 0;
    int                dPulses = 0;
    int                reqCycles = 0;
    int                stallCnt = 0;
    int                waitCnt = 0;
    bit                respPending = 1'b0;
    logic [DATA_W-1:0] pendingData = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .D_FIRST(1)) dut (
        .clk(clk), .rst(rst),
        .icache_req_valid_i(icache_req_valid_i), .icache_addr_i(icache_addr_i),
        .icache_data_wen_i(icache_data_wen_i), .icache_data_i(icache_data_i),
        .icache_data_valid_o(icache_data_valid_o), .icache_data_o(icache_data_o),
        .dcache_req_valid_i(dcache_req_valid_i), .dcache_addr_i(dcache_addr_i),
        .dcache_data_wen_i(dcache_data_wen_i), .dcache_data_i(dcache_data_i),
        .dcache_data_valid_o(dcache_data_valid_o), .dcache_data_o(dcache_data_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_addr_o(mem_addr_o), .mem_wen_o(mem_wen_o), .mem_wdata_o(mem_wdata_o),
        .mem_resp_valid_i(mem_resp_valid_i), .mem_rdata_i(mem_rdata_i)
    );

    function automatic logic [DATA_W-1:0] memData(input logic [ADDR_W-1:0] addr);
        if (addr == 64'h8000_0000) return 64'h13;
        return {addr[31:0] ^ 32'h5A5A_5A5A, addr[63:32] ^ 32'hC3C3_C3C3};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    function automatic void pushExp(input logic side, input logic [ADDR_W-1:0] addr,
                                    input logic wen, input logic [DATA_W-1:0] wdata);
        txn_t t;
        t.side = side; t.addr = addr; t.wen = wen; t.wdata = wdata; t.rdata = memData(addr);
        expQ.push_back(t);
    endfunction

    task automatic applyStimulus(input logic side, input logic [ADDR_W-1:0] addr,
                                 input logic wen, input logic [DATA_W-1:0] wdata);
        if (side == ARB_GRANT_D) begin
            dcache_req_valid_i = 1'b1; dcache_addr_i = addr; dcache_data_wen_i = wen; dcache_data_i = wdata;
        end else begin
            icache_req_valid_i = 1'b1; icache_addr_i = addr; icache_data_wen_i = wen; icache_data_i = wdata;
        end
        pushExp(side, addr, wen, wdata);
    endtask

    task automatic waitPulse(input string tag, input int maxCycles, output int cycles);
        logic got;
        got = 1'b0;
        cycles = 0;
        while (cycles < maxCycles && !got) begin
            @(negedge clk);
            cycles++;
            got = icache_data_valid_o || dcache_data_valid_o;
        end
        checkOutput({tag, " completion"}, got, 1'b1);
    endtask

    // Memory model: optional ready stall, then a response after an optional wait.
    initial begin
        mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_rdata_i = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_req_ready_i  = 1'b0;
            mem_resp_valid_i = 1'b0;
            if (rst !== 1'b1) begin
                respPending = 1'b0; stallCnt = 0; waitCnt = 0;
            end else if (respPending) begin
                if (waitCnt < respDelay) begin
                    waitCnt++;
                end else begin
                    mem_resp_valid_i = 1'b1; mem_rdata_i = pendingData;
                    respPending = 1'b0; waitCnt = 0;
                end
            end else if (mem_req_valid_o) begin
                if (stallCnt < readyDelay) begin
                    stallCnt++;
                end else begin
                    mem_req_ready_i = 1'b1; respPending = 1'b1;
                    pendingData = memData(mem_addr_o); stallCnt = 0;
                end
            end
        end
    end

    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (mem_req_valid_o) begin
                    reqCycles++;
                    if (expQ.size() > 0) begin
                        checkOutput("mem_addr", mem_addr_o, expQ[0].addr);
                        checkOutput("mem_wen", mem_wen_o, expQ[0].wen);
                        checkOutput("mem_wdata", mem_wdata_o, expQ[0].wdata);
                    end else begin
                        checkOutput("request with no stimulus", expQ.size(), 1);
                    end
                end
                if (icache_data_valid_o || dcache_data_valid_o) begin
                    checkOutput("both valids", icache_data_valid_o && dcache_data_valid_o, 1'b0);
                    if (icache_data_valid_o) iPulses++;
                    if (dcache_data_valid_o) dPulses++;
                    if (expQ.size() > 0) begin
                        t = expQ.pop_front();
                        checkOutput("grant side", dcache_data_valid_o, t.side);
                        checkOutput("read data", t.side ? dcache_data_o : icache_data_o, t.rdata);
                    end else begin
                        checkOutput("pulse with no stimulus", expQ.size(), 1);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat, lat2, c0, p0;
        rst = 1'b0;
        icache_req_valid_i = 0; icache_addr_i = '0; icache_data_wen_i = 0; icache_data_i = '0;
        dcache_req_valid_i = 0; dcache_addr_i = '0; dcache_data_wen_i = 0; dcache_data_i = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset state", dut.r_state, ARB_IDLE);
        checkOutput("reset mem_req_valid", mem_req_valid_o, 0);
        checkOutput("reset mem_addr", mem_addr_o, 0);
        checkOutput("reset mem_wen", mem_wen_o, 0);
        checkOutput("reset mem_wdata", mem_wdata_o, 0);
        checkOutput("reset valids", {icache_data_valid_o, dcache_data_valid_o}, 0);
        checkOutput("reset icache_data", icache_data_o, 0);
        checkOutput("reset dcache_data", dcache_data_o, 0);
        rst = 1'b1;

        // Simultaneous requests straight out of reset: D,I,D,I at one per 4 cycles.
        @(negedge clk);
        applyStimulus(ARB_GRANT_D, 64'h8000_4000, 1'b0, '0);
        applyStimulus(ARB_GRANT_I, 64'h8000_5000, 1'b0, '0);
        pushExp(ARB_GRANT_D, 64'h8000_4000, 1'b0, '0);
        pushExp(ARB_GRANT_I, 64'h8000_5000, 1'b0, '0);
        for (int k = 0; k < 4; k++) begin
            waitPulse("contention", 20, lat);
            checkOutput("contention order", dcache_data_valid_o, (k % 2 == 0));
            checkOutput("contention latency", lat, (k == 0) ? 3 : 4);
        end
        icache_req_valid_i = 0; dcache_req_valid_i = 0;

        // Icache-only read.
        @(negedge clk);
        p0 = dPulses;
        applyStimulus(ARB_GRANT_I, 64'h8000_0000, 1'b0, '0);
        waitPulse("icache read", 20, lat);
        checkOutput("icache read latency", lat, 3);
        checkOutput("icache read data", icache_data_o, 64'h13);
        icache_req_valid_i = 0;
        @(negedge clk);
        checkOutput("icache pulse width", icache_data_valid_o, 0);
        checkOutput("dcache idle during icache", dPulses - p0, 0);

        // Dcache write.
        applyStimulus(ARB_GRANT_D, 64'h8000_1000, 1'b1, 64'hDEAD_BEEF_CAFE_F00D);
        waitPulse("dcache write", 20, lat);
        checkOutput("dcache write latency", lat, 3);
        dcache_req_valid_i = 0;
        @(negedge clk);
        checkOutput("dcache pulse width", dcache_data_valid_o, 0);

        // Ready stall with the address input changed after the grant.
        readyDelay = 5;
        c0 = reqCycles;
        applyStimulus(ARB_GRANT_D, 64'h8000_2000, 1'b0, '0);
        @(negedge clk);
        dcache_addr_i = 64'h1234;
        waitPulse("ready stall", 30, lat2);
        checkOutput("ready stall latency", lat2 + 1, 8);
        checkOutput("stall valid cycles", reqCycles - c0, 6);
        dcache_req_valid_i = 0;
        readyDelay = 0;
        @(negedge clk);

        // Request dropped one cycle after the grant.
        p0 = iPulses;
        applyStimulus(ARB_GRANT_I, 64'h8000_3000, 1'b0, '0);
        @(negedge clk);
        icache_req_valid_i = 0;
        waitPulse("dropped request", 20, lat2);
        checkOutput("dropped request latency", lat2 + 1, 3);
        c0 = reqCycles;
        repeat (5) @(negedge clk);
        checkOutput("no reissue after drop", reqCycles - c0, 0);
        checkOutput("dropped request pulses", iPulses - p0, 1);

        // Reset while waiting for the response.
        respDelay = 3;
        applyStimulus(ARB_GRANT_D, 64'h8000_6000, 1'b0, '0);
        repeat (2) @(negedge clk);
        checkOutput("in RESP before reset", dut.r_state, ARB_RESP);
        rst = 1'b0;
        dcache_req_valid_i = 0;
        @(negedge clk);
        checkOutput("mid reset state", dut.r_state, ARB_IDLE);
        checkOutput("mid reset mem_req_valid", mem_req_valid_o, 0);
        checkOutput("mid reset mem_addr", mem_addr_o, 0);
        checkOutput("mid reset valids", {icache_data_valid_o, dcache_data_valid_o}, 0);
        checkOutput("mid reset dcache_data", dcache_data_o, 0);
        checkOutput("mid reset icache_data", icache_data_o, 0);
        expQ.delete();
        respDelay = 0;
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(ARB_GRANT_I, 64'h8000_0000, 1'b0, '0);
        waitPulse("post reset read", 20, lat);
        checkOutput("post reset latency", lat, 3);
        icache_req_valid_i = 0;
        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
